// File: rtl/uart_tx_pkg.sv
// Purpose : shared UART transmit types, state encoding and line-mux select codes.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
package uart_tx_pkg;

    // Transmit frame sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Line-mux select codes. The external line mux uses the same constants.
    localparam logic [1:0] MUX_START  = 2'b00;  // drive 0
    localparam logic [1:0] MUX_IDLE   = 2'b01;  // drive 1 (idle and stop bit)
    localparam logic [1:0] MUX_DATA   = 2'b10;  // drive ser_data
    localparam logic [1:0] MUX_PARITY = 2'b11;  // drive par_bit

    // Line-mux select that belongs to a given sequencer state.
    function automatic logic [1:0] state_mux_sel(input tx_state_t st);
        logic [1:0] sel;
        case (st)
            ST_START:  sel = MUX_START;
            ST_DATA:   sel = MUX_DATA;
            ST_PARITY: sel = MUX_PARITY;
            default:   sel = MUX_IDLE;
        endcase
        return sel;
    endfunction

    // Bit-index width; a 1-bit character still needs a 1-bit counter.
    function automatic int cnt_width(input int data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Purpose : parity of a latched character; even (par_typ=0) or odd (par_typ=1).
// Latency : combinational; the caller registers the result.
// Backpr. : none.
//
// Ports:
//   data     in  DATA_WIDTH  latched character
//   par_typ  in  1           0 = even, 1 = odd
//   par_bit  out 1           XOR of all data bits XOR par_typ
module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// Purpose : UART transmit frame sequencer driving a 4-way line mux (start/data/parity/stop).
// Latency : START shows on the outputs one cycle after data_valid is sampled in IDLE.
// Backpr. : data_valid is honoured only while busy=0; requests during a frame are dropped.
//
// Ports:
//   clk         in   1           one serial bit period per cycle
//   rst         in   1           synchronous, active-high
//   p_data      in   DATA_WIDTH  character to send
//   data_valid  in   1           send request
//   par_en      in   1           1 = append parity bit
//   par_typ     in   1           0 = even, 1 = odd parity
//   mux_sel     out  2           line-mux select (codes in uart_tx_pkg)
//   ser_data    out  1           current data bit, LSB first
//   par_bit     out  1           parity bit
//   busy        out  1           high from start bit through stop bit
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int               CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_t             state_q;
    tx_state_t             state_nxt;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [CNT_W-1:0]      bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  accept;
    logic                  par_calc;

    logic [1:0]            mux_sel_nxt;
    logic                  busy_nxt;
    logic                  ser_data_nxt;
    logic                  par_bit_nxt;

    // A request is taken only from IDLE; the frame settings are frozen here so
    // later input changes cannot disturb the frame in flight.
    assign accept = (state_q == ST_IDLE) && data_valid;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (data_q),
        .par_typ (par_typ_q),
        .par_bit (par_calc)
    );

    // State register together with the output and datapath flops. Outputs are
    // loaded from next-state decode so every port comes straight off a flop
    // while still lining up with the state it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            mux_sel   <= MUX_IDLE;
            busy      <= 1'b0;
            ser_data  <= 1'b0;
            par_bit   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            bit_cnt_q <= bit_cnt_nxt;
            mux_sel   <= mux_sel_nxt;
            busy      <= busy_nxt;
            ser_data  <= ser_data_nxt;
            par_bit   <= par_bit_nxt;
            if (accept) begin
                data_q    <= p_data;
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (data_valid) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    state_nxt = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                state_nxt = ST_STOP;
            end
            ST_STOP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values, decoded from the state being entered.
    // ser_data and par_bit hold whenever their field is not being entered.
    always_comb begin
        mux_sel_nxt  = state_mux_sel(state_nxt);
        busy_nxt     = (state_nxt != ST_IDLE);
        bit_cnt_nxt  = bit_cnt_q;
        ser_data_nxt = ser_data;
        par_bit_nxt  = par_bit;
        case (state_nxt)
            ST_DATA: begin
                // Restart the index on entry from START, otherwise advance.
                bit_cnt_nxt  = (state_q == ST_DATA) ? bit_cnt_q + 1'b1 : '0;
                ser_data_nxt = data_q[bit_cnt_nxt];
            end
            ST_PARITY: begin
                par_bit_nxt = par_calc;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, frame data bits per character.
REQ-002 SHALL have port clk  input  1  single clock, one serial bit period per cycle.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port p_data  input  DATA_WIDTH  parallel character to send.
REQ-005 SHALL have port data_valid  input  1  request to send p_data; honoured only when busy=0.
REQ-006 SHALL have port par_en  input  1  1 = append parity bit to the frame.
REQ-007 SHALL have port par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port mux_sel  output  2  line-mux select: 00 start(0), 01 idle/stop(1), 10 ser_data, 11 par_bit.
REQ-009 SHALL have port ser_data  output  1  current data bit, LSB first.
REQ-010 SHALL have port par_bit  output  1  computed parity bit.
REQ-011 SHALL have port busy  output  1  high from start bit through stop bit.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL drive every output from a flop: no combinational input-to-output path.
REQ-014 IDLE: mux_sel=01, busy=0; data_valid=1 at an edge latches p_data, par_en and par_typ, then moves to START.
REQ-015 START: mux_sel=00, busy=1, lasts exactly one cycle, then moves to DATA.
REQ-016 DATA: mux_sel=10, lasts DATA_WIDTH cycles, ser_data = latched bit i in the i-th cycle (i=0 first).
REQ-017 After the last DATA cycle: go to PARITY if latched par_en=1, else to STOP.
REQ-018 PARITY: mux_sel=11, lasts one cycle, par_bit = XOR of latched data XOR latched par_typ.
REQ-019 STOP: mux_sel=01, busy=1, lasts one cycle, then moves to IDLE.
REQ-020 Latency: START appears on outputs in the cycle after data_valid is sampled.
REQ-021 Frame length (busy high): DATA_WIDTH+3 cycles with parity, DATA_WIDTH+2 without.
REQ-022 data_valid while busy=1 (including the STOP cycle) SHALL be ignored; no queuing, no abort.
REQ-023 Changes on p_data, par_en or par_typ after acceptance SHALL NOT affect the frame in flight.
REQ-024 Minimum gap between frames: one IDLE cycle (mux_sel=01, busy=0).
REQ-025 Bit counter width: clog2(DATA_WIDTH); counter resets to 0 on every entry to DATA.
REQ-026 par_bit SHALL hold its value outside PARITY; ser_data SHALL hold its value outside DATA.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE: mux_sel=01, busy=0, ser_data=0, par_bit=0, bit counter=0, data register=0.
REQ-028 Reset mid-frame SHALL abort the frame; the line reads idle (01) on the next cycle, and the partial frame is not resumed.
REQ-029 data_valid asserted together with rst SHALL be ignored.

Structure
REQ-030 Package uart_tx_pkg SHALL hold the state enum and the four mux_sel encoding constants, shared with the line mux.
REQ-031 Parity SHALL be a sub-module uart_parity_calc: latched data plus par_typ in, one bit out.
REQ-032 Serializer shift/index logic SHALL stay inside uart_tx_ctrl.

Verification
REQ-033 p_data=0xA5, par_en=1, par_typ=0 -> mux_sel 00, 10x8, 11, 01; ser_data 1,0,1,0,0,1,0,1; par_bit=0; busy high 11 cycles.
REQ-034 p_data=0xA5, par_en=1, par_typ=1 -> par_bit=1; p_data=0x01 with even parity -> par_bit=1.
REQ-035 p_data=0xFF, par_en=0 -> no 11 cycle, STOP follows the 8th data bit, busy high 10 cycles.
REQ-036 data_valid re-pulsed with p_data=0x3C mid-frame and in the STOP cycle -> ignored, frame intact; held high continuously -> one IDLE cycle between frames.
REQ-037 rst pulsed during DATA bit 4 -> next cycle mux_sel=01, busy=0, ser_data=0, par_bit=0; next accepted frame is correct.
